// File: rtl/patch_pos_gen.sv
`default_nettype none
// ============================================================================
// Module      : patch_pos_gen
// Description : Walks all patch positions of a HEIGHT x WIDTH image, issuing
//               LANES vertically adjacent rows per beat over valid/ready.
// Revision    : 1.0 - initial parametrised multi-lane release
// ============================================================================
module patch_pos_gen #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32,
    parameter int LANES  = 8,
    parameter int CW     = $clog2((WIDTH > HEIGHT) ? WIDTH : HEIGHT) + 1,
    parameter int BW     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [2:0]              patch_size,
    input  logic [2:0]              stride,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        lane_valid,
    output logic [LANES*CW-1:0]     y_cor,
    output logic [LANES*HEIGHT-1:0] y_therm,
    output logic [CW-1:0]           x_cor,
    output logic [WIDTH-1:0]        x_therm,
    output logic [BW-1:0]           beat_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [2:0]              st_q;
    logic [CW-1:0]           ny_q, nx_q, ybase_q, ridx_q, x_q, xidx_q;
    logic [BW-1:0]           beat_q;
    logic [LANES-1:0]        lv_q, lv_d;
    logic [LANES*CW-1:0]     ycor_q, ycor_d;
    logic [LANES*HEIGHT-1:0] ytherm_q, ytherm_d;
    logic [WIDTH-1:0]        xtherm_q, xtherm_d;
    logic                    cfg_err_q;

    logic                    cfg_ok, load, acc, wrap, last, adv, flush;
    logic [2:0]              st_sel, div;
    logic [CW-1:0]           ny_calc, nx_calc, ny_sel, step;
    logic [CW-1:0]           ybase_d, ridx_d, x_d, xidx_d;
    logic [CW-1:0]           off [LANES];

    assign cfg_ok  = (patch_size != 3'd0) && (stride != 3'd0) &&
                     (int'(patch_size) <= HEIGHT) && (int'(patch_size) <= WIDTH);
    assign div     = (stride == 3'd0) ? 3'd1 : stride;
    assign ny_calc = CW'((HEIGHT - int'(patch_size)) / int'(div) + 1);
    assign nx_calc = CW'((WIDTH  - int'(patch_size)) / int'(div) + 1);

    assign load   = (state_q == S_IDLE) && start && cfg_ok;
    assign acc    = (state_q == S_RUN) && out_ready && !abort;
    assign wrap   = (int'(ridx_q) + LANES) >= int'(ny_q);
    assign last   = wrap && (xidx_q == nx_q - CW'(1));
    assign adv    = acc && !last;
    assign flush  = (state_q == S_RUN) && (abort || (out_ready && last));
    assign st_sel = load ? stride : st_q;
    assign ny_sel = load ? ny_calc : ny_q;

    // Lane offsets k*stride built as a running sum so no per-beat multiplier exists
    always_comb begin
        off[0] = '0;
        for (int k = 1; k < LANES; k++) begin
            off[k] = off[k-1] + CW'(st_sel);
        end
        step = off[LANES-1] + CW'(st_sel);
    end

    always_comb begin
        ybase_d = '0;
        ridx_d  = '0;
        x_d     = '0;
        xidx_d  = '0;
        if (!load) begin
            if (wrap) begin
                x_d    = x_q + CW'(st_q);
                xidx_d = xidx_q + CW'(1);
            end else begin
                ybase_d = ybase_q + step;
                ridx_d  = ridx_q + CW'(LANES);
                x_d     = x_q;
                xidx_d  = xidx_q;
            end
        end
    end

    always_comb begin
        lv_d     = '0;
        ycor_d   = '0;
        ytherm_d = '0;
        xtherm_d = '0;
        for (int k = 0; k < LANES; k++) begin
            if ((int'(ridx_d) + k) < int'(ny_sel)) begin
                lv_d[k]               = 1'b1;
                ycor_d[k*CW +: CW]    = ybase_d + off[k];
                for (int i = 0; i < HEIGHT; i++) begin
                    ytherm_d[k*HEIGHT + i] = i < int'(ybase_d + off[k]);
                end
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            xtherm_d[i] = i < int'(x_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= '0;
            ny_q      <= '0;
            nx_q      <= '0;
            ybase_q   <= '0;
            ridx_q    <= '0;
            x_q       <= '0;
            xidx_q    <= '0;
            beat_q    <= '0;
            lv_q      <= '0;
            ycor_q    <= '0;
            ytherm_q  <= '0;
            xtherm_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= (state_q == S_IDLE) && start && !cfg_ok;
            if (load) begin
                st_q <= stride;
                ny_q <= ny_calc;
                nx_q <= nx_calc;
            end
            if (load || adv) begin
                ybase_q  <= ybase_d;
                ridx_q   <= ridx_d;
                x_q      <= x_d;
                xidx_q   <= xidx_d;
                lv_q     <= lv_d;
                ycor_q   <= ycor_d;
                ytherm_q <= ytherm_d;
                xtherm_q <= xtherm_d;
                beat_q   <= load ? '0 : beat_q + BW'(1);
            end else if (flush) begin
                ybase_q  <= '0;
                ridx_q   <= '0;
                x_q      <= '0;
                xidx_q   <= '0;
                lv_q     <= '0;
                ycor_q   <= '0;
                ytherm_q <= '0;
                xtherm_q <= '0;
                beat_q   <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // abort outranks acceptance of the final beat, so no done follows it
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (load) state_d = S_RUN;
            S_RUN:   if (abort) state_d = S_IDLE;
                     else if (out_ready && last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == S_RUN);
        busy      = (state_q == S_RUN);
        done      = (state_q == S_DONE);
    end

    assign lane_valid = lv_q;
    assign y_cor      = ycor_q;
    assign y_therm    = ytherm_q;
    assign x_cor      = x_q;
    assign x_therm    = xtherm_q;
    assign beat_idx   = beat_q;
    assign cfg_err    = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_patch_pos_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_patch_pos_gen
// Description : Directed self-checking bench for patch_pos_gen.
// Revision    : 1.0
// ============================================================================
module tb_patch_pos_gen;
    localparam int W  = 32;
    localparam int H  = 32;
    localparam int L  = 8;
    localparam int CW = 6;
    localparam int BW = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start, abort, out_ready;
    logic [2:0]     patch_size, stride;
    logic           out_valid, busy, done, cfg_err;
    logic [L-1:0]   lane_valid;
    logic [L*CW-1:0] y_cor;
    logic [L*H-1:0] y_therm;
    logic [CW-1:0]  x_cor;
    logic [W-1:0]   x_therm;
    logic [BW-1:0]  beat_idx;

    patch_pos_gen #(.WIDTH(W), .HEIGHT(H), .LANES(L), .CW(CW), .BW(BW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .patch_size(patch_size), .stride(stride),
        .out_valid(out_valid), .out_ready(out_ready),
        .lane_valid(lane_valid), .y_cor(y_cor), .y_therm(y_therm),
        .x_cor(x_cor), .x_therm(x_therm), .beat_idx(beat_idx),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [L-1:0]    cap_lv [256];
    logic [L*CW-1:0] cap_yc [256];
    logic [L*H-1:0]  cap_yt [256];
    logic [CW-1:0]   cap_x  [256];

    typedef struct {
        int         ps;
        int         st;
        int         beat;
        logic [7:0] lv;
        int         y0;
        int         y1;
        int         x;
        logic [31:0] t1;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference beat derived from the beat number: column = b / groups, group = b % groups
    task automatic model(input int ps, input int st, input int b,
                         output logic [L-1:0] lv, output logic [L*CW-1:0] yc,
                         output logic [L*H-1:0] yt, output logic [CW-1:0] xc,
                         output logic [W-1:0] xt);
        int ny, ng, col, grp, row;
        ny  = (H - ps) / st + 1;
        ng  = (ny + L - 1) / L;
        col = b / ng;
        grp = b % ng;
        lv = '0; yc = '0; yt = '0; xt = '0;
        xc = CW'(col * st);
        for (int i = 0; i < W; i++) xt[i] = (i < col * st);
        for (int k = 0; k < L; k++) begin
            row = grp * L + k;
            if (row < ny) begin
                lv[k] = 1'b1;
                yc[k*CW +: CW] = CW'(row * st);
                for (int i = 0; i < H; i++) yt[k*H + i] = (i < row * st);
            end
        end
    endtask

    task automatic run_scan(input int ps, input int st, input bit bp, input int abort_at,
                            input bit start_in_done, output int nbeats, output int ndone);
        logic [L-1:0]    elv, plv;
        logic [L*CW-1:0] eyc, pyc;
        logic [L*H-1:0]  eyt, pyt;
        logic [CW-1:0]   exc, pxc;
        logic [W-1:0]    ext, pxt;
        logic [BW-1:0]   pbi;
        bit stalled, fin;
        nbeats = 0; ndone = 0; stalled = 0; fin = 0;
        patch_size = 3'(ps); stride = 3'(st); start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("first_valid", out_valid, 1);
        chk("first_busy", busy, 1);
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            if (done) begin
                ndone++; fin = 1;
                chk("valid_at_done", out_valid, 0);
                chk("busy_at_done", busy, 0);
                if (start_in_done) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("done_width", done, 0);
                chk("busy_after_done", busy, 0);
                if (start_in_done) begin
                    @(negedge clk);
                    chk("start_in_done_ignored", busy, 0);
                    chk("start_in_done_no_valid", out_valid, 0);
                end
            end else if (out_valid) begin
                if (stalled) begin
                    chk("stall_lane_valid", lane_valid, plv);
                    chk("stall_y_cor", y_cor, pyc);
                    chk("stall_y_therm", y_therm, pyt);
                    chk("stall_x", {x_therm, x_cor}, {pxt, pxc});
                    chk("stall_beat_idx", beat_idx, pbi);
                end
                if (nbeats == abort_at) begin
                    abort = 1'b1; out_ready = 1'b1;
                    @(negedge clk);
                    abort = 1'b0; out_ready = 1'b0;
                    chk("abort_valid", out_valid, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_no_done", done, 0);
                    repeat (3) begin
                        @(negedge clk);
                        chk("abort_no_done_later", done, 0);
                    end
                    fin = 1;
                end else begin
                    out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (out_ready) begin
                        model(ps, st, nbeats, elv, eyc, eyt, exc, ext);
                        chk("lane_valid", lane_valid, elv);
                        chk("y_cor", y_cor, eyc);
                        chk("y_therm", y_therm, eyt);
                        chk("x_cor", x_cor, exc);
                        chk("x_therm", x_therm, ext);
                        chk("beat_idx", beat_idx, nbeats);
                        cap_lv[nbeats] = lane_valid; cap_yc[nbeats] = y_cor;
                        cap_yt[nbeats] = y_therm;    cap_x[nbeats]  = x_cor;
                        nbeats++;
                        stalled = 0;
                    end else begin
                        plv = lane_valid; pyc = y_cor; pyt = y_therm;
                        pxc = x_cor; pxt = x_therm; pbi = beat_idx;
                        stalled = 1;
                    end
                    @(negedge clk);
                end
            end else begin
                chk("valid_until_done", out_valid, 1);
                fin = 1;
            end
        end
        if (!fin) chk("scan_timeout", 0, 1);
        out_ready = 1'b0;
    endtask

    task automatic check_table(input int ps);
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].ps == ps) begin
                chk("tbl_lane_valid", cap_lv[tbl[i].beat], tbl[i].lv);
                chk("tbl_y0", cap_yc[tbl[i].beat][CW-1:0], tbl[i].y0);
                chk("tbl_y1", cap_yc[tbl[i].beat][2*CW-1:CW], tbl[i].y1);
                chk("tbl_x", cap_x[tbl[i].beat], tbl[i].x);
                chk("tbl_therm1", cap_yt[tbl[i].beat][2*H-1:H], tbl[i].t1);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nb, nd;
        tbl[0] = '{ps: 3, st: 1, beat: 0,  lv: 8'hFF, y0: 0,  y1: 1,  x: 0,  t1: 32'h0000_0001};
        tbl[1] = '{ps: 3, st: 1, beat: 3,  lv: 8'h3F, y0: 24, y1: 25, x: 0,  t1: 32'h01FF_FFFF};
        tbl[2] = '{ps: 3, st: 1, beat: 4,  lv: 8'hFF, y0: 0,  y1: 1,  x: 1,  t1: 32'h0000_0001};
        tbl[3] = '{ps: 3, st: 1, beat: 119, lv: 8'h3F, y0: 24, y1: 25, x: 29, t1: 32'h01FF_FFFF};
        tbl[4] = '{ps: 5, st: 3, beat: 0,  lv: 8'hFF, y0: 0,  y1: 3,  x: 0,  t1: 32'h0000_0007};
        tbl[5] = '{ps: 5, st: 3, beat: 1,  lv: 8'h03, y0: 24, y1: 27, x: 0,  t1: 32'h07FF_FFFF};
        tbl[6] = '{ps: 5, st: 3, beat: 2,  lv: 8'hFF, y0: 0,  y1: 3,  x: 3,  t1: 32'h0000_0007};
        tbl[7] = '{ps: 5, st: 3, beat: 19, lv: 8'h03, y0: 24, y1: 27, x: 27, t1: 32'h07FF_FFFF};

        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        patch_size = 3'd3; stride = 3'd1;
        repeat (2) @(negedge clk);
        chk("reset_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_beat", {lane_valid, x_cor, beat_idx}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_scan(3, 1, 1'b0, -1, 1'b0, nb, nd);
        chk("beats_3_1", nb, 120);
        chk("done_3_1", nd, 1);
        check_table(3);

        run_scan(5, 3, 1'b0, -1, 1'b1, nb, nd);
        chk("beats_5_3", nb, 20);
        chk("done_5_3", nd, 1);
        check_table(5);

        run_scan(3, 1, 1'b1, -1, 1'b0, nb, nd);
        chk("beats_bp_3_1", nb, 120);
        chk("done_bp_3_1", nd, 1);
        run_scan(5, 3, 1'b1, -1, 1'b0, nb, nd);
        chk("beats_bp_5_3", nb, 20);
        chk("done_bp_5_3", nd, 1);

        patch_size = 3'd3; stride = 3'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cfg_err_stride0", cfg_err, 1);
        chk("cfg_err_stride0_busy", busy, 0);
        chk("cfg_err_stride0_valid", out_valid, 0);
        @(negedge clk);
        chk("cfg_err_pulse", cfg_err, 0);
        chk("cfg_err_stride0_valid2", out_valid, 0);
        patch_size = 3'd0; stride = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cfg_err_ps0", cfg_err, 1);
        chk("cfg_err_ps0_busy", busy, 0);
        @(negedge clk);
        chk("cfg_err_ps0_valid", out_valid, 0);

        run_scan(3, 1, 1'b0, 10, 1'b0, nb, nd);
        chk("abort_beats", nb, 10);
        chk("abort_done_count", nd, 0);
        run_scan(3, 1, 1'b0, -1, 1'b0, nb, nd);
        chk("restart_beats", nb, 120);

        patch_size = 3'd3; stride = 3'd1; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_lanes", {lane_valid, y_cor}, 0);
        chk("async_rst_therm", y_therm, 0);
        chk("async_rst_x", {x_cor, x_therm, beat_idx}, 0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", busy, 0);
        run_scan(3, 1, 1'b0, -1, 1'b0, nb, nd);
        chk("post_rst_beats", nb, 120);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
